cg_rvarch_issue_scoreboard: RTL and testbench

Single-issue RAW/WAW interlock between RV32I decode and execute. Holds one decoded instruction in an issue register. Tracks architectural registers with an outstanding write, and stalls decode until the instruction's sources and destination are free. Writeback clears the tracking; flush discards the held instruction without leaking busy state.

---
 rtl/cg_rvarch_issue_scoreboard.sv | 197 +++++++++++++++++++
 tb/tb_cg_rvarch_issue_scoreboard.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_rvarch_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// cg_rvarch_issue_scoreboard
//
// Single-issue RAW/WAW interlock that sits between RV32I decode and execute.
// It holds one decoded instruction in an issue register. It keeps a busy bit
// for each architectural register that has an issued write still outstanding.
// Decode is stalled until the offered instruction's sources and destination
// are free. Writeback clears a busy bit. Flush drops the held instruction and
// leaves the busy bits alone.
//
// Optional feature macro: CG_RVARCH_SCOREBOARD_WB_BYPASS_EN
//   When it is defined, a writeback arriving in the current cycle masks that
//   register's busy bit in the hazard check. A dependent instruction is then
//   accepted in the same cycle as its producer's writeback. When it is not
//   defined, the hazard check uses registered state only.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_dec_valid / o_dec_ready      decode handshake
//   i_dec_instr, i_dec_pc          offered instruction and its PC
//   o_issue_valid / i_issue_ready  execute handshake
//   o_issue_instr, o_issue_pc      held instruction and PC (registered)
//   i_wb_valid, i_wb_rd            writeback completion
//   i_flush                        drop held instruction, block accept
//   o_busy                         busy vector (bit 0 always 0)
//   o_wb_err                       one-cycle pulse on writeback to a free reg or x0
// ---------------------------------------------------------------------------
module cg_rvarch_issue_scoreboard #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_dec_valid,
    output logic                   o_dec_ready,
    input  logic [INSTR_WIDTH-1:0] i_dec_instr,
    input  logic [PC_WIDTH-1:0]    i_dec_pc,
    output logic                   o_issue_valid,
    input  logic                   i_issue_ready,
    output logic [INSTR_WIDTH-1:0] o_issue_instr,
    output logic [PC_WIDTH-1:0]    o_issue_pc,
    input  logic                   i_wb_valid,
    input  logic [4:0]             i_wb_rd,
    input  logic                   i_flush,
    output logic [31:0]            o_busy,
    output logic                   o_wb_err
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Registered state
    logic                   hold_valid_reg;
    logic [INSTR_WIDTH-1:0] hold_instr_reg;
    logic [PC_WIDTH-1:0]    hold_pc_reg;
    logic                   hold_wr_reg;
    logic [4:0]             hold_rd_reg;
    logic [31:0]            busy_reg;
    logic                   wb_err_reg;

    logic [31:0]            busy_next;
    logic                   wb_err_next;

    // Decode of the offered instruction
    logic [6:0] dec_opcode;
    logic [4:0] dec_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       dec_wr;
    logic       dec_r1;
    logic       dec_r2;

    assign dec_opcode = i_dec_instr[6:0];
    assign dec_rd     = i_dec_instr[11:7];
    assign dec_rs1    = i_dec_instr[19:15];
    assign dec_rs2    = i_dec_instr[24:20];

    always_comb begin
        dec_wr = 1'b0;
        dec_r1 = 1'b0;
        dec_r2 = 1'b0;
        case (dec_opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                dec_wr = 1'b1;
                dec_r1 = 1'b1;
            end
            OPC_OP: begin
                dec_wr = 1'b1;
                dec_r1 = 1'b1;
                dec_r2 = 1'b1;
            end
            OPC_AUIPC, OPC_LUI, OPC_JAL: begin
                dec_wr = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                dec_r1 = 1'b1;
                dec_r2 = 1'b1;
            end
            default: ;  // MISC_MEM, SYSTEM, custom, FP: no tracking
        endcase
        // x0 is never a real dependency
        dec_wr = dec_wr & (dec_rd  != 5'd0);
        dec_r1 = dec_r1 & (dec_rs1 != 5'd0);
        dec_r2 = dec_r2 & (dec_rs2 != 5'd0);
    end

    // Pending set: issued-but-not-written-back registers, plus the held
    // instruction's destination (it is not in busy yet but will be soon).
    logic [31:0] held_mask;
    logic [31:0] busy_chk;
    logic [31:0] pend;
    logic        hazard;
    logic        accept;
    logic        issue_fire;

    assign held_mask = (hold_valid_reg && hold_wr_reg) ? (32'd1 << hold_rd_reg) : 32'd0;

`ifdef CG_RVARCH_SCOREBOARD_WB_BYPASS_EN
    // Only the busy part is masked by a same-cycle writeback. The held rd has
    // not issued yet, so a writeback cannot be for it.
    logic [31:0] wb_mask;
    assign wb_mask  = i_wb_valid ? (32'd1 << i_wb_rd) : 32'd0;
    assign busy_chk = busy_reg & ~wb_mask;
`else
    assign busy_chk = busy_reg;
`endif

    assign pend   = busy_chk | held_mask;
    assign hazard = (dec_r1 & pend[dec_rs1])
                  | (dec_r2 & pend[dec_rs2])
                  | (dec_wr & pend[dec_rd]);

    assign o_dec_ready = !i_flush && !hazard && (!hold_valid_reg || i_issue_ready);
    assign accept      = i_dec_valid && o_dec_ready;
    assign issue_fire  = hold_valid_reg && i_issue_ready;

    // Per-register busy update. When issue sets a bit and writeback clears
    // the same bit in one cycle, the set wins: the writeback belongs to an
    // older producer, and the new one is still outstanding.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_busy
            if (gi == 0) begin : g_x0
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                logic set_bit;
                logic clr_bit;
                assign set_bit = issue_fire && hold_wr_reg && (hold_rd_reg == 5'(gi));
                assign clr_bit = i_wb_valid && (i_wb_rd == 5'(gi));
                assign busy_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_reg[gi]);
            end
        end
    endgenerate

    assign wb_err_next = i_wb_valid && ((i_wb_rd == 5'd0) || !busy_reg[i_wb_rd]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_valid_reg <= 1'b0;
            hold_instr_reg <= '0;
            hold_pc_reg    <= '0;
            hold_wr_reg    <= 1'b0;
            hold_rd_reg    <= 5'd0;
            busy_reg       <= 32'd0;
            wb_err_reg     <= 1'b0;
        end else begin
            busy_reg   <= busy_next;
            wb_err_reg <= wb_err_next;
            // Flush also forces o_dec_ready low, so accept cannot happen here
            if (i_flush) begin
                hold_valid_reg <= 1'b0;
            end else if (accept) begin
                hold_valid_reg <= 1'b1;
                hold_instr_reg <= i_dec_instr;
                hold_pc_reg    <= i_dec_pc;
                hold_wr_reg    <= dec_wr;
                hold_rd_reg    <= dec_rd;
            end else if (issue_fire) begin
                hold_valid_reg <= 1'b0;
            end
        end
    end

    assign o_issue_valid = hold_valid_reg;
    assign o_issue_instr = hold_instr_reg;
    assign o_issue_pc    = hold_pc_reg;
    assign o_busy        = busy_reg;
    assign o_wb_err      = wb_err_reg;

endmodule

// File: tb/tb_cg_rvarch_issue_scoreboard.sv
`timescale 1ns/1ps
module tb_cg_rvarch_issue_scoreboard;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] LUI_X0  = 32'h00001037;
    localparam logic [31:0] ADD_X2  = 32'h00108133;
    localparam logic [31:0] SW_X1   = 32'h00112023;
`ifdef CG_RVARCH_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [31:0] dec_instr = 32'd0;
    logic [31:0] dec_pc = 32'd0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic        flush = 1'b0;
    logic [31:0] busy;
    logic        wb_err;

    int errors = 0;
    int checks = 0;

    cg_rvarch_issue_scoreboard #(.INSTR_WIDTH(32), .PC_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
        .i_dec_instr(dec_instr), .i_dec_pc(dec_pc),
        .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
        .o_issue_instr(issue_instr), .o_issue_pc(issue_pc),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
        .i_flush(flush), .o_busy(busy), .o_wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Register file view: which registers have an issued write outstanding,
    // plus the one instruction currently parked for execute.
    bit          m_busy[32];
    bit          m_hv;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_err;

    function automatic void classify(input logic [31:0] ins, output bit w, output bit a, output bit b);
        logic [6:0] op;
        op = ins[6:0];
        w = 0; a = 0; b = 0;
        case (op)
            7'h03, 7'h13, 7'h67: begin w = 1; a = 1; end   // LOAD, OP_IMM, JALR
            7'h33:               begin w = 1; a = 1; b = 1; end // OP
            7'h17, 7'h37, 7'h6F: w = 1;                    // AUIPC, LUI, JAL
            7'h63, 7'h23:        begin a = 1; b = 1; end   // BRANCH, STORE
            default: ;
        endcase
        if (ins[11:7] == 0)  w = 0;
        if (ins[19:15] == 0) a = 0;
        if (ins[24:20] == 0) b = 0;
    endfunction

    function automatic bit reg_in_use(input int r);
        bit hw, ha, hb;
        bit from_busy;
        classify(m_instr, hw, ha, hb);
        from_busy = m_busy[r] && !(BYP && wb_valid && (int'(wb_rd) == r));
        return from_busy || (m_hv && hw && (int'(m_instr[11:7]) == r));
    endfunction

    function automatic bit model_ready();
        bit w, a, b;
        classify(dec_instr, w, a, b);
        if (flush) return 0;
        if (m_hv && !issue_ready) return 0;
        if (a && reg_in_use(int'(dec_instr[19:15]))) return 0;
        if (b && reg_in_use(int'(dec_instr[24:20]))) return 0;
        if (w && reg_in_use(int'(dec_instr[11:7]))) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        m_hv = 0; m_instr = 32'd0; m_pc = 32'd0; m_err = 0;
    endtask

    task automatic model_clock();
        bit rdy, acc, fire, hw, ha, hb;
        rdy  = model_ready();
        acc  = dec_valid && rdy;
        fire = m_hv && issue_ready;
        classify(m_instr, hw, ha, hb);
        m_err = wb_valid && (wb_rd == 0 || !m_busy[wb_rd]);
        if (wb_valid) m_busy[wb_rd] = 0;
        if (fire && hw) m_busy[m_instr[11:7]] = 1;
        m_busy[0] = 0;
        if (flush) m_hv = 0;
        else if (acc) begin m_hv = 1; m_instr = dec_instr; m_pc = dec_pc; end
        else if (fire) m_hv = 0;
    endtask

    // Advance one clock; returns at the following negedge.
    task automatic cycle();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_instr = 0; dec_pc = 0; issue_ready = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1;
        dec_valid = 1; dec_instr = ADDI_X1;
        #1;
        checks++;
        if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", issue_valid); end
        checks++;
        if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
        checks++;
        if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
        checks++;
        if (issue_instr !== 32'd0 || issue_pc !== 32'd0) begin
            errors++; $display("FAIL reset_instr_pc got=%h/%h exp=0/0", issue_instr, issue_pc);
        end
        checks++;
        if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", dec_ready); end
        dec_valid = 0;
        @(negedge clk);
        $display("txn reset done");
    endtask

    task automatic test_independent();
        dec_valid = 1; dec_instr = ADDI_X1; dec_pc = 32'h100; issue_ready = 1;
        #1;
        checks++;
        if (dec_ready !== 1'b1) begin errors++; $display("FAIL indep_ready got=%b exp=1", dec_ready); end
        cycle();
        checks++;
        if (issue_valid !== 1'b1 || issue_instr !== ADDI_X1 || issue_pc !== 32'h100) begin
            errors++; $display("FAIL indep_issue got=%b/%h/%h exp=1/%h/100", issue_valid, issue_instr, issue_pc, ADDI_X1);
        end
        checks++;
        if (busy !== 32'd0) begin errors++; $display("FAIL indep_busy0 got=%h exp=0", busy); end
        for (int k = 0; k < 3; k++) begin
            dec_instr = LUI_X0; dec_pc = 32'h104 + 32'(4 * k);
            #1;
            checks++;
            if (dec_ready !== 1'b1) begin errors++; $display("FAIL indep_lui_ready%0d got=%b exp=1", k, dec_ready); end
            cycle();
            checks++;
            if (busy !== 32'h2 || issue_instr !== LUI_X0 || issue_valid !== 1'b1) begin
                errors++; $display("FAIL indep_lui%0d got busy=%h instr=%h exp busy=2 instr=%h", k, busy, issue_instr, LUI_X0);
            end
            $display("txn lui x0 accepted pc=%h busy=%h", dec_pc, busy);
        end
        dec_valid = 0;
        cycle();
        checks++;
        if (issue_valid !== 1'b0 || busy !== 32'h2) begin
            errors++; $display("FAIL indep_drain got=%b/%h exp=0/2", issue_valid, busy);
        end
    endtask

    task automatic test_raw_stall();
        bit accepted;
        dec_valid = 1; dec_instr = ADD_X2; dec_pc = 32'h200; issue_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall%0d got=%b exp=0", k, dec_ready); end
            cycle();
        end
        wb_valid = 1; wb_rd = 5'd1;
        #1;
        checks++;
        if (dec_ready !== BYP) begin errors++; $display("FAIL raw_wb_ready got=%b exp=%b", dec_ready, BYP); end
        accepted = BYP;
        cycle();
        wb_valid = 0;
        checks++;
        if (wb_err !== 1'b0) begin errors++; $display("FAIL raw_wb_err got=%b exp=0", wb_err); end
        if (!accepted) begin
            #1;
            checks++;
            if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb_ready got=%b exp=1", dec_ready); end
            cycle();
        end
        checks++;
        if (issue_valid !== 1'b1 || issue_instr !== ADD_X2) begin
            errors++; $display("FAIL raw_issue got=%b/%h exp=1/%h", issue_valid, issue_instr, ADD_X2);
        end
        dec_valid = 0;
        cycle();
        checks++;
        if (busy !== 32'h4) begin errors++; $display("FAIL raw_busy got=%h exp=4", busy); end
        $display("txn add x2,x1,x1 issued busy=%h", busy);
        wb_valid = 1; wb_rd = 5'd2;
        cycle();
        wb_valid = 0;
        checks++;
        if (busy !== 32'd0) begin errors++; $display("FAIL raw_clear got=%h exp=0", busy); end
    endtask

    task automatic test_backpressure();
        dec_valid = 1; dec_instr = ADDI_X1; dec_pc = 32'h300; issue_ready = 0;
        cycle();
        dec_instr = ADD_X2; dec_pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (dec_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%b exp=0", k, dec_ready); end
            cycle();
            checks++;
            if (issue_valid !== 1'b1 || issue_instr !== ADDI_X1 || issue_pc !== 32'h300) begin
                errors++; $display("FAIL bp_stable%0d got=%h/%h exp=%h/300", k, issue_instr, issue_pc, ADDI_X1);
            end
        end
        // Execute now ready: the held rd alone must still block the add
        issue_ready = 1;
        #1;
        checks++;
        if (dec_ready !== 1'b0) begin errors++; $display("FAIL bp_held_rd got=%b exp=0", dec_ready); end
        cycle();
        checks++;
        if (issue_valid !== 1'b0 || busy !== 32'h2) begin
            errors++; $display("FAIL bp_fire got=%b/%h exp=0/2", issue_valid, busy);
        end
        dec_valid = 0; wb_valid = 1; wb_rd = 5'd1;
        cycle();
        wb_valid = 0;
        checks++;
        if (busy !== 32'd0) begin errors++; $display("FAIL bp_clear got=%h exp=0", busy); end
        $display("txn backpressure addi x1 held then issued");
    endtask

    task automatic test_store();
        bit accepted;
        dec_valid = 1; dec_instr = ADDI_X1; dec_pc = 32'h400; issue_ready = 1;
        cycle();
        dec_valid = 0;
        cycle();
        dec_valid = 1; dec_instr = SW_X1; dec_pc = 32'h404;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (dec_ready !== 1'b0) begin errors++; $display("FAIL sw_stall%0d got=%b exp=0", k, dec_ready); end
            cycle();
        end
        wb_valid = 1; wb_rd = 5'd1;
        #1;
        accepted = BYP;
        checks++;
        if (dec_ready !== BYP) begin errors++; $display("FAIL sw_wb_ready got=%b exp=%b", dec_ready, BYP); end
        cycle();
        wb_valid = 0;
        if (!accepted) begin
            #1;
            checks++;
            if (dec_ready !== 1'b1) begin errors++; $display("FAIL sw_after_wb got=%b exp=1", dec_ready); end
            cycle();
        end
        dec_valid = 0;
        cycle();
        checks++;
        if (busy !== 32'd0 || issue_valid !== 1'b0) begin
            errors++; $display("FAIL sw_busy got=%h/%b exp=0/0", busy, issue_valid);
        end
        $display("txn sw x1,0(x2) issued busy=%h", busy);
    endtask

    task automatic test_flush();
        dec_valid = 1; dec_instr = ADDI_X1; dec_pc = 32'h500; issue_ready = 0;
        cycle();
        dec_valid = 0; flush = 1;
        #1;
        checks++;
        if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", dec_ready); end
        cycle();
        flush = 0;
        checks++;
        if (issue_valid !== 1'b0 || busy !== 32'd0) begin
            errors++; $display("FAIL flush_clear got=%b/%h exp=0/0", issue_valid, busy);
        end
        dec_valid = 1; dec_instr = ADD_X2; dec_pc = 32'h504;
        #1;
        checks++;
        if (dec_ready !== 1'b1) begin errors++; $display("FAIL flush_next_ready got=%b exp=1", dec_ready); end
        cycle();
        checks++;
        if (issue_valid !== 1'b1 || issue_instr !== ADD_X2) begin
            errors++; $display("FAIL flush_next_issue got=%b/%h exp=1/%h", issue_valid, issue_instr, ADD_X2);
        end
        dec_valid = 0; issue_ready = 1;
        cycle();
        wb_valid = 1; wb_rd = 5'd2;
        cycle();
        wb_valid = 0;
        checks++;
        if (busy !== 32'd0 || wb_err !== 1'b0) begin
            errors++; $display("FAIL flush_tail got=%h/%b exp=0/0", busy, wb_err);
        end
        $display("txn flush dropped addi x1");
    endtask

    task automatic test_error();
        wb_valid = 1; wb_rd = 5'd5;
        cycle();
        wb_valid = 0;
        checks++;
        if (wb_err !== 1'b1 || busy !== 32'd0) begin
            errors++; $display("FAIL err_pulse got=%b/%h exp=1/0", wb_err, busy);
        end
        cycle();
        checks++;
        if (wb_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", wb_err); end
        wb_valid = 1; wb_rd = 5'd0;
        cycle();
        wb_valid = 0;
        checks++;
        if (wb_err !== 1'b1) begin errors++; $display("FAIL err_x0 got=%b exp=1", wb_err); end
        cycle();
        checks++;
        if (wb_err !== 1'b0) begin errors++; $display("FAIL err_x0_clear got=%b exp=0", wb_err); end
        $display("txn wb error pulses checked");
    endtask

    task automatic test_reset_mid();
        dec_valid = 1; dec_instr = ADDI_X1; dec_pc = 32'h600; issue_ready = 1;
        cycle();
        issue_ready = 0; dec_instr = LUI_X0; dec_pc = 32'h604;
        cycle();
        #2 rst_n = 0;
        #1;
        checks++;
        if (issue_valid !== 1'b0 || busy !== 32'd0 || issue_instr !== 32'd0 || issue_pc !== 32'd0) begin
            errors++; $display("FAIL reset_mid got=%b/%h/%h/%h exp=0/0/0/0", issue_valid, busy, issue_instr, issue_pc);
        end
        idle_inputs();
        @(negedge clk);
        model_reset();
        rst_n = 1;
        $display("txn asynchronous reset mid-operation");
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops[9];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h73, 7'h0F};
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 8)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    task automatic test_random();
        bit exp_rdy;
        int issued = 0;
        for (int n = 0; n < 1500; n++) begin
            dec_valid   = 1'($urandom_range(0, 1));
            dec_instr   = rand_instr();
            dec_pc      = $urandom;
            issue_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_rd       = 5'($urandom_range(0, 3));
            #1;
            exp_rdy = model_ready();
            checks++;
            if (dec_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, dec_ready, exp_rdy);
            end
            if (m_hv && issue_ready) issued++;
            cycle();
            checks++;
            if (issue_valid !== m_hv) begin
                errors++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, issue_valid, m_hv);
            end
            if (m_hv) begin
                checks++;
                if (issue_instr !== m_instr || issue_pc !== m_pc) begin
                    errors++; $display("FAIL rand_payload n=%0d got=%h/%h exp=%h/%h", n, issue_instr, issue_pc, m_instr, m_pc);
                end
            end
            checks++;
            if (busy !== model_busy_vec()) begin
                errors++; $display("FAIL rand_busy n=%0d got=%h exp=%h", n, busy, model_busy_vec());
            end
            checks++;
            if (wb_err !== m_err) begin
                errors++; $display("FAIL rand_wb_err n=%0d got=%b exp=%b", n, wb_err, m_err);
            end
        end
        idle_inputs();
        $display("txn random run issued=%0d", issued);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_independent();
        test_raw_stall();
        test_backpressure();
        test_store();
        test_flush();
        test_error();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #500000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
